// File: rtl/vernier_frontend.sv
// Vernier TDC front end: synchronizes gate/ref2/control inputs, counts coarse reference
// cycles across a gate window, and captures the first vernier coincidence index.
module vernier_frontend #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             reference_clk_1_internal,
  input  logic             rst_i,
  input  logic             gate_i,
  input  logic             ref2_i,
  input  logic             clear_i,
  input  logic             ack_i,
  output logic [CNT_W-1:0] coarse_count_o,
  output logic [CNT_W-1:0] coincidence_count_o,
  output logic             result_valid_o,
  output logic             overflow_o,
  output logic             missed_o,
  output logic [1:0]       state_o
);

  localparam int unsigned SYNC_W = 2;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_DONE    = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  logic [SYNC_W-1:0] r_gate_sync;
  logic [SYNC_W-1:0] r_ref2_sync;
  logic [SYNC_W-1:0] r_clear_sync;
  logic [SYNC_W-1:0] r_ack_sync;
  logic              r_gate_q;
  logic              r_ref2_q;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  r_coin_cnt;
  logic              r_coin_seen;

  logic              w_gate_s;
  logic              w_ref2_s;
  logic              w_clear_s;
  logic              w_ack_s;
  logic              w_gate_rise;
  logic              w_gate_fall;
  logic              w_ref2_rise;
  logic              w_cnt_sat;
  logic [CNT_W-1:0]  w_cnt_next;

  assign w_gate_s    = r_gate_sync[SYNC_W-1];
  assign w_ref2_s    = r_ref2_sync[SYNC_W-1];
  assign w_clear_s   = r_clear_sync[SYNC_W-1];
  assign w_ack_s     = r_ack_sync[SYNC_W-1];
  assign w_gate_rise = w_gate_s & ~r_gate_q;
  assign w_gate_fall = ~w_gate_s & r_gate_q;
  assign w_ref2_rise = w_ref2_s & ~r_ref2_q;
  assign w_cnt_sat   = (r_cnt == CNT_MAX);
  assign w_cnt_next  = w_cnt_sat ? r_cnt : r_cnt + CNT_W'(1);
  assign state_o     = r_state;

  // Two-stage synchronizers plus one delay stage for edge detection
  always_ff @(posedge reference_clk_1_internal or posedge rst_i) begin
    if (rst_i) begin
      r_gate_sync  <= '0;
      r_ref2_sync  <= '0;
      r_clear_sync <= '0;
      r_ack_sync   <= '0;
      r_gate_q     <= 1'b0;
      r_ref2_q     <= 1'b0;
    end else begin
      r_gate_sync  <= {r_gate_sync[0], gate_i};
      r_ref2_sync  <= {r_ref2_sync[0], ref2_i};
      r_clear_sync <= {r_clear_sync[0], clear_i};
      r_ack_sync   <= {r_ack_sync[0], ack_i};
      r_gate_q     <= w_gate_s;
      r_ref2_q     <= w_ref2_s;
    end
  end

  // Measurement FSM with registered result outputs; clear overrides all transitions
  always_ff @(posedge reference_clk_1_internal or posedge rst_i) begin
    if (rst_i) begin
      r_state             <= S_IDLE;
      r_cnt               <= '0;
      r_coin_cnt          <= '0;
      r_coin_seen         <= 1'b0;
      coarse_count_o      <= '0;
      coincidence_count_o <= '0;
      result_valid_o      <= 1'b0;
      overflow_o          <= 1'b0;
      missed_o            <= 1'b0;
    end else if (w_clear_s) begin
      r_state             <= S_IDLE;
      r_cnt               <= '0;
      r_coin_cnt          <= '0;
      r_coin_seen         <= 1'b0;
      coarse_count_o      <= '0;
      coincidence_count_o <= '0;
      result_valid_o      <= 1'b0;
      overflow_o          <= 1'b0;
      missed_o            <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_gate_rise) begin
            r_cnt       <= CNT_W'(1);
            r_coin_seen <= 1'b0;
            r_state     <= S_RUN;
          end
        end
        S_RUN: begin
          if (w_gate_fall) begin
            coarse_count_o <= r_cnt;
            result_valid_o <= 1'b1;
            r_state        <= S_DONE;
            // A ref2 rise coinciding with the gate fall lands at the unincremented count
            if (r_coin_seen) begin
              coincidence_count_o <= r_coin_cnt;
            end else if (w_ref2_rise) begin
              coincidence_count_o <= r_cnt;
              r_coin_cnt          <= r_cnt;
              r_coin_seen         <= 1'b1;
            end else begin
              coincidence_count_o <= '1;
            end
          end else begin
            r_cnt <= w_cnt_next;
            if (w_cnt_sat) begin
              overflow_o <= 1'b1;
            end
            if (w_ref2_rise && !r_coin_seen) begin
              r_coin_cnt  <= w_cnt_next;
              r_coin_seen <= 1'b1;
            end
          end
        end
        S_DONE: begin
          if (w_gate_rise) begin
            missed_o <= 1'b1;
          end
          if (w_ack_s) begin
            result_valid_o <= 1'b0;
            r_state        <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          if (w_gate_rise) begin
            missed_o <= 1'b1;
          end
          if (!w_ack_s) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vernier_frontend.sv
// Directed bench for vernier_frontend: a 32-bit and a 4-bit instance share stimulus.
module tb_vernier_frontend;

  logic        clk;
  logic        rst_i;
  logic        gate_i;
  logic        ref2_i;
  logic        clear_i;
  logic        ack_i;

  logic [31:0] coarse32;
  logic [31:0] coin32;
  logic        valid32;
  logic        ovf32;
  logic        missed32;
  logic [1:0]  state32;

  logic [3:0]  coarse4;
  logic [3:0]  coin4;
  logic        valid4;
  logic        ovf4;
  logic        missed4;
  logic [1:0]  state4;

  int n_tests;
  int n_fail;

  vernier_frontend #(.CNT_W(32)) u_dut32 (
    .reference_clk_1_internal (clk),
    .rst_i                    (rst_i),
    .gate_i                   (gate_i),
    .ref2_i                   (ref2_i),
    .clear_i                  (clear_i),
    .ack_i                    (ack_i),
    .coarse_count_o           (coarse32),
    .coincidence_count_o      (coin32),
    .result_valid_o           (valid32),
    .overflow_o               (ovf32),
    .missed_o                 (missed32),
    .state_o                  (state32)
  );

  vernier_frontend #(.CNT_W(4)) u_dut4 (
    .reference_clk_1_internal (clk),
    .rst_i                    (rst_i),
    .gate_i                   (gate_i),
    .ref2_i                   (ref2_i),
    .clear_i                  (clear_i),
    .ack_i                    (ack_i),
    .coarse_count_o           (coarse4),
    .coincidence_count_o      (coin4),
    .result_valid_o           (valid4),
    .overflow_o               (ovf4),
    .missed_o                 (missed4),
    .state_o                  (state4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Gate high for n edges; ref2 first rises when cnt == ref_cnt, then toggles.
  // simul puts a ref2 rise on the same edge the gate fall is seen.
  task automatic gate_pulse(input int n, input int ref_cnt, input logic simul, input string tag);
    for (int c = 1; c <= n; c++) begin
      gate_i = 1'b1;
      ref2_i = (ref_cnt > 0 && c >= ref_cnt && ((c - ref_cnt) % 4) < 2);
      cyc(1);
    end
    gate_i = 1'b0;
    ref2_i = simul;
    cyc(1);
    ref2_i = 1'b0;
    cyc(1);
    check({tag, "_valid_before_3rd"}, 32'(valid32), 32'd0);
    cyc(1);
    check({tag, "_valid_at_3rd"}, 32'(valid32), 32'd1);
  endtask

  task automatic ack_cycle();
    ack_i = 1'b1;
    cyc(3);
    ack_i = 1'b0;
    cyc(3);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_i   = 1'b1;
    gate_i  = 1'b0;
    ref2_i  = 1'b0;
    clear_i = 1'b0;
    ack_i   = 1'b0;
    cyc(2);
    check("rst_state", 32'(state32), 32'd0);
    check("rst_valid", 32'(valid32), 32'd0);
    check("rst_coarse", coarse32, 32'd0);
    rst_i = 1'b0;
    cyc(2);

    // Basic: 10-edge gate, no ref2
    gate_pulse(10, 0, 1'b0, "basic");
    check("basic_coarse", coarse32, 32'd10);
    check("basic_coin", coin32, 32'hFFFF_FFFF);
    check("basic_state", 32'(state32), 32'd2);
    ack_cycle();
    check("basic_idle", 32'(state32), 32'd0);

    // Coincidence at cnt 5, later ref2 rises ignored
    gate_pulse(12, 5, 1'b0, "coin");
    check("coin_coarse", coarse32, 32'd12);
    check("coin_coin", coin32, 32'd5);

    // Gate pulse during DONE, then handshake
    gate_i = 1'b1;
    cyc(3);
    gate_i = 1'b0;
    cyc(4);
    check("hs_missed", 32'(missed32), 32'd1);
    check("hs_coarse_held", coarse32, 32'd12);
    check("hs_coin_held", coin32, 32'd5);
    check("hs_valid_held", 32'(valid32), 32'd1);
    check("hs_state_done", 32'(state32), 32'd2);
    ack_i = 1'b1;
    cyc(3);
    check("hs_state_release", 32'(state32), 32'd3);
    check("hs_valid_drop", 32'(valid32), 32'd0);
    ack_i = 1'b0;
    cyc(3);
    check("hs_state_idle", 32'(state32), 32'd0);

    // Clear mid-RUN
    gate_i = 1'b1;
    cyc(5);
    check("clr_running", 32'(state32), 32'd1);
    clear_i = 1'b1;
    cyc(1);
    clear_i = 1'b0;
    cyc(3);
    check("clr_state", 32'(state32), 32'd0);
    check("clr_coarse", coarse32, 32'd0);
    check("clr_coin", coin32, 32'd0);
    check("clr_missed", 32'(missed32), 32'd0);
    cyc(2);
    check("clr_no_restart", 32'(state32), 32'd0);
    gate_i = 1'b0;
    cyc(4);
    gate_pulse(6, 0, 1'b0, "post_clr");
    check("post_clr_coarse", coarse32, 32'd6);
    ack_cycle();

    // Saturation on the 4-bit instance with ref2 rise on the gate-fall edge
    gate_pulse(20, 0, 1'b1, "sat");
    check("sat4_coarse", 32'(coarse4), 32'd15);
    check("sat4_ovf", 32'(ovf4), 32'd1);
    check("sat4_coin", 32'(coin4), 32'd15);
    check("sat32_coarse", coarse32, 32'd20);
    check("sat32_coin", coin32, 32'd20);
    check("sat32_ovf", 32'(ovf32), 32'd0);
    ack_cycle();

    // Asynchronous reset mid-RUN
    gate_i = 1'b1;
    cyc(6);
    check("rr_running", 32'(state32), 32'd1);
    rst_i = 1'b1;
    #1;
    check("rr_state", 32'(state32), 32'd0);
    check("rr_coarse", coarse32, 32'd0);
    check("rr_coin", coin32, 32'd0);
    check("rr_ovf4", 32'(ovf4), 32'd0);
    check("rr_valid", 32'(valid32), 32'd0);
    gate_i = 1'b0;
    cyc(2);
    rst_i = 1'b0;
    cyc(8);
    check("rr_no_pulse", 32'(valid32), 32'd0);
    check("rr_idle", 32'(state32), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
